// File: rtl/game_ctrl_fsm.sv
// Game flow controller: sequences play, pause, level/world advance, life
// loss, win/lose screens and restart. Counters (level, world, lives) are
// registered; all other outputs are a Moore decode of the current state.
// Optional feature: define GAME_BONUS_LIFE_EN to award one life (saturating
// at LIVES_MAX) on every world advance.
module game_ctrl_fsm #(
  parameter int LEVEL_MAX    = 3,
  parameter int WORLD_MAX    = 6,
  parameter int START_LIVES  = 7,
  parameter int LIVES_MAX    = 15,
  parameter int LVL_W        = 3,
  parameter int WLD_W        = 3,
  parameter int LIV_W        = 5,
  parameter int DISP_TIMEOUT = 500000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             continue_btn,
  input  logic             start_btn,
  input  logic             player_dead,
  input  logic             level_complete,
  input  logic             seqEnd,
  output logic [LVL_W-1:0] level,
  output logic [WLD_W-1:0] world,
  output logic [LIV_W-1:0] lives,
  output logic [2:0]       screen,
  output logic             playerDisable,
  output logic             resetSelect,
  output logic [2:0]       audioSelect,
  output logic             audioEnable
);

  localparam int TMR_W = $clog2(DISP_TIMEOUT) + 1;

  localparam logic [LVL_W-1:0] LEVEL_LAST = LVL_W'(LEVEL_MAX - 1);
  localparam logic [WLD_W-1:0] WORLD_LAST = WLD_W'(WORLD_MAX - 1);
  localparam logic [LIV_W-1:0] LIVES_INIT = LIV_W'(START_LIVES);
  localparam logic [LIV_W-1:0] LIVES_CAP  = LIV_W'(LIVES_MAX);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(DISP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    INIT      = 4'd0,
    PLAY      = 4'd1,
    PAUSE     = 4'd2,
    LVL_UP    = 4'd3,
    LVL_DISP  = 4'd4,
    WLD_UP    = 4'd5,
    WLD_DISP  = 4'd6,
    LIFE_DECR = 4'd7,
    LIFE_WAIT = 4'd8,
    WIN       = 4'd9,
    WIN_WAIT  = 4'd10,
    LOSE      = 4'd11,
    LOSE_WAIT = 4'd12,
    RESET     = 4'd13
  } state_t;

  state_t           state, state_next;
  logic             start_q;
  logic             start_edge;
  logic [TMR_W-1:0] timer;
  logic             disp_done;

  assign start_edge = start_btn & ~start_q;
  assign disp_done  = (continue_btn & seqEnd) | (timer == TMR_LAST);

  // State register and start button edge-detect register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start_btn;
    end
  end

  // Display timer: restarts on every state change, saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || (state_next != state)) begin
      timer <= '0;
    end else if (timer != TMR_LAST) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Level / world / lives counters, updated while in the event states
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      world <= '0;
      lives <= LIVES_INIT;
    end else begin
      unique case (state)
        INIT, RESET: begin
          level <= '0;
          world <= '0;
          lives <= LIVES_INIT;
        end
        PLAY: begin
          // Final death zeroes lives together with the move to LOSE so the
          // lose screen already shows 0.
          if (player_dead && (lives <= LIV_W'(1))) lives <= '0;
        end
        LVL_UP: begin
          if (level < LEVEL_LAST) level <= level + LVL_W'(1);
        end
        WLD_UP: begin
          if (world < WORLD_LAST) world <= world + WLD_W'(1);
          level <= '0;
`ifdef GAME_BONUS_LIFE_EN
          if (lives < LIVES_CAP) lives <= lives + LIV_W'(1);
`endif
        end
        LIFE_DECR: begin
          if (lives != '0) lives <= lives - LIV_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state selection and Moore output decode
  always_comb begin
    state_next    = state;
    screen        = 3'd0;
    playerDisable = 1'b1;
    resetSelect   = 1'b0;
    audioSelect   = 3'd7;
    audioEnable   = 1'b0;
    unique case (state)
      INIT: begin
        screen = 3'd1;
        if (continue_btn) state_next = PLAY;
      end
      PLAY: begin
        screen        = 3'd1;
        playerDisable = 1'b0;
        if (player_dead) begin
          state_next = (lives > LIV_W'(1)) ? LIFE_DECR : LOSE;
        end else if (level_complete) begin
          if (level < LEVEL_LAST)      state_next = LVL_UP;
          else if (world < WORLD_LAST) state_next = WLD_UP;
          else                         state_next = WIN;
        end else if (start_edge) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        screen = 3'd6;
        if (start_edge) state_next = PLAY;
      end
      LVL_UP: begin
        audioSelect = 3'd2;
        audioEnable = 1'b1;
        state_next  = LVL_DISP;
      end
      LVL_DISP: begin
        screen = 3'd4;
        if (disp_done) state_next = PLAY;
      end
      WLD_UP: begin
        audioSelect = 3'd3;
        audioEnable = 1'b1;
        state_next  = WLD_DISP;
      end
      WLD_DISP: begin
        screen = 3'd5;
        if (disp_done) state_next = PLAY;
      end
      LIFE_DECR: begin
        playerDisable = 1'b0;
        audioSelect   = 3'd4;
        audioEnable   = 1'b1;
        state_next    = LIFE_WAIT;
      end
      LIFE_WAIT: begin
        playerDisable = 1'b0;
        audioSelect   = 3'd1;
        if (!player_dead) state_next = PLAY;
      end
      WIN: begin
        screen      = 3'd3;
        audioSelect = 3'd5;
        audioEnable = 1'b1;
        state_next  = WIN_WAIT;
      end
      WIN_WAIT: begin
        screen = 3'd3;
        if (disp_done) state_next = RESET;
      end
      LOSE: begin
        screen      = 3'd2;
        audioSelect = 3'd6;
        audioEnable = 1'b1;
        state_next  = LOSE_WAIT;
      end
      LOSE_WAIT: begin
        screen = 3'd2;
        if (disp_done) state_next = RESET;
      end
      RESET: begin
        resetSelect = 1'b1;
        state_next  = INIT;
      end
      default: begin
        state_next = RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench for game_ctrl_fsm. Stimulus pushes the expected output
// snapshot and the cycle it must appear on; a monitor pops an entry every
// time any DUT output changes and compares value and cycle.
module tb_game_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst, continue_btn, start_btn, player_dead, level_complete, seqEnd;
  logic [2:0] level, world;
  logic [4:0] lives;
  logic [2:0] screen;
  logic       playerDisable, resetSelect, audioEnable;
  logic [2:0] audioSelect;

  game_ctrl_fsm #(
    .LIVES_MAX   (9),
    .DISP_TIMEOUT(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .continue_btn  (continue_btn),
    .start_btn     (start_btn),
    .player_dead   (player_dead),
    .level_complete(level_complete),
    .seqEnd        (seqEnd),
    .level         (level),
    .world         (world),
    .lives         (lives),
    .screen        (screen),
    .playerDisable (playerDisable),
    .resetSelect   (resetSelect),
    .audioSelect   (audioSelect),
    .audioEnable   (audioEnable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] scr;
    logic       pd;
    logic       rs;
    logic [2:0] asel;
    logic       aen;
    logic [2:0] lvl;
    logic [2:0] wld;
    logic [4:0] liv;
  } snap_t;

  typedef struct {
    snap_t s;
    int    at;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    have_prev = 1'b0;
  snap_t prev;
  snap_t cur;

  int m_lvl, m_wld, m_liv;

  always_comb begin
    cur.scr  = screen;
    cur.pd   = playerDisable;
    cur.rs   = resetSelect;
    cur.asel = audioSelect;
    cur.aen  = audioEnable;
    cur.lvl  = level;
    cur.wld  = world;
    cur.liv  = lives;
  end

  always @(posedge clk) cyc++;

  // Monitor: every output change consumes one scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!have_prev || (cur != prev)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc %0d: actual %h required no change", cyc, cur);
        end else begin
          e = q.pop_front();
          if ((cur !== e.s) || (cyc != e.at)) begin
            errors++;
            $display("FAIL outputs cyc %0d: actual %h required %h at cyc %0d", cyc, cur, e.s, e.at);
          end
        end
      end
      prev      = cur;
      have_prev = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected snapshot d cycles from now, counters taken from the model
  task automatic expect_at(input int d, input logic [2:0] scr, input logic pd,
                           input logic rs, input logic [2:0] asel, input logic aen);
    exp_t e;
    e.s.scr  = scr;
    e.s.pd   = pd;
    e.s.rs   = rs;
    e.s.asel = asel;
    e.s.aen  = aen;
    e.s.lvl  = 3'(m_lvl);
    e.s.wld  = 3'(m_wld);
    e.s.liv  = 5'(m_liv);
    e.at     = cyc + d;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_lvl = 0;
    m_wld = 0;
    m_liv = 7;
  endtask

  // One level_complete pulse from PLAY (not the final one), back to PLAY
  task automatic complete_level(input bit use_timeout);
    level_complete = 1'b1;
    if (m_lvl < 2) begin
      expect_at(1, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1);
      tick(1);
      level_complete = 1'b0;
      m_lvl++;
      expect_at(1, 3'd4, 1'b1, 1'b0, 3'd7, 1'b0);
      tick(1);
    end else begin
      expect_at(1, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1);
      tick(1);
      level_complete = 1'b0;
      m_lvl = 0;
      m_wld++;
`ifdef GAME_BONUS_LIFE_EN
      if (m_liv < 9) m_liv++;
`endif
      expect_at(1, 3'd5, 1'b1, 1'b0, 3'd7, 1'b0);
      tick(1);
    end
    if (use_timeout) begin
      expect_at(16, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
      tick(16);
    end else begin
      continue_btn = 1'b1;
      seqEnd       = 1'b1;
      expect_at(1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
      tick(1);
      continue_btn = 1'b0;
      seqEnd       = 1'b0;
    end
  endtask

  // One non-fatal death from PLAY, back to PLAY
  task automatic lose_life();
    player_dead = 1'b1;
    expect_at(1, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1);
    tick(1);
    player_dead = 1'b0;
    m_liv--;
    expect_at(1, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    tick(1);
    expect_at(1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
    tick(1);
  endtask

  initial begin
    rst = 1'b1; continue_btn = 1'b0; start_btn = 1'b0;
    player_dead = 1'b0; level_complete = 1'b0; seqEnd = 1'b0;
    model_reset();
    tick(1);
    expect_at(0, 3'd1, 1'b1, 1'b0, 3'd7, 1'b0);
    mon_en = 1'b1;
    tick(1);
    rst = 1'b0;

    // Start game
    continue_btn = 1'b1;
    expect_at(1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
    tick(1);
    continue_btn = 1'b0;

    // Two level-ups (second exits by timeout), then a world-up
    complete_level(1'b0);
    complete_level(1'b1);
    complete_level(1'b0);

    // Death and level_complete together: death wins; hold dead in LIFE_WAIT
    player_dead    = 1'b1;
    level_complete = 1'b1;
    expect_at(1, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1);
    tick(1);
    level_complete = 1'b0;
    m_liv--;
    expect_at(1, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    tick(1);
    tick(10);
    player_dead = 1'b0;
    expect_at(1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
    tick(1);

    // Pause on held start_btn: one edge only, level_complete ignored
    start_btn = 1'b1;
    expect_at(1, 3'd6, 1'b1, 1'b0, 3'd7, 1'b0);
    tick(1);
    level_complete = 1'b1;
    tick(19);
    start_btn      = 1'b0;
    level_complete = 1'b0;
    tick(3);
    start_btn = 1'b1;
    expect_at(1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
    tick(1);
    start_btn = 1'b0;

    // Burn lives down to 1, then final death -> LOSE -> timeout -> RESET -> INIT
    while (m_liv > 1) lose_life();
    player_dead = 1'b1;
    m_liv = 0;
    expect_at(1, 3'd2, 1'b1, 1'b0, 3'd6, 1'b1);
    tick(1);
    player_dead = 1'b0;
    expect_at(1, 3'd2, 1'b1, 1'b0, 3'd7, 1'b0);
    tick(1);
    expect_at(16, 3'd0, 1'b1, 1'b1, 3'd7, 1'b0);
    tick(16);
    model_reset();
    expect_at(1, 3'd1, 1'b1, 1'b0, 3'd7, 1'b0);
    tick(1);
    tick(2);

    // Full game to WIN
    continue_btn = 1'b1;
    expect_at(1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
    tick(1);
    continue_btn = 1'b0;
    while (!(m_lvl == 2 && m_wld == 5)) complete_level(1'b0);
    level_complete = 1'b1;
    expect_at(1, 3'd3, 1'b1, 1'b0, 3'd5, 1'b1);
    tick(1);
    level_complete = 1'b0;
    expect_at(1, 3'd3, 1'b1, 1'b0, 3'd7, 1'b0);
    tick(1);
    continue_btn = 1'b1;
    tick(3);
    seqEnd = 1'b1;
    expect_at(1, 3'd0, 1'b1, 1'b1, 3'd7, 1'b0);
    tick(1);
    continue_btn = 1'b0;
    seqEnd       = 1'b0;
    model_reset();
    expect_at(1, 3'd1, 1'b1, 1'b0, 3'd7, 1'b0);
    tick(1);

    // Reset in the middle of a level-up overrides everything
    continue_btn = 1'b1;
    expect_at(1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0);
    tick(1);
    continue_btn   = 1'b0;
    level_complete = 1'b1;
    expect_at(1, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1);
    tick(1);
    level_complete = 1'b0;
    rst            = 1'b1;
    player_dead    = 1'b1;
    expect_at(1, 3'd1, 1'b1, 1'b0, 3'd7, 1'b0);
    tick(1);
    rst         = 1'b0;
    player_dead = 1'b0;
    tick(5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d entries left required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm.md
GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 Parameter LEVEL_MAX, default 3, levels per world (level runs 0..LEVEL_MAX-1).
REQ-002 Parameter WORLD_MAX, default 6, worlds per game (world runs 0..WORLD_MAX-1).
REQ-003 Parameter START_LIVES, default 7, lives loaded at game start.
REQ-004 Parameter LIVES_MAX, default 15, lives saturation ceiling; START_LIVES <= LIVES_MAX.
REQ-005 Parameter LVL_W / WLD_W / LIV_W, defaults 3 / 3 / 5, widths of level / world / lives.
REQ-006 Parameter DISP_TIMEOUT, default 500000000, cycles before a display screen auto-advances.
REQ-007 clk  in  1  system clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 continue_btn  in  1  advance/confirm, level sensitive.
REQ-010 start_btn  in  1  pause toggle, rising-edge detected internally.
REQ-011 player_dead  in  1  from player object.
REQ-012 level_complete  in  1  from scroll module.
REQ-013 seqEnd  in  1  audio sequence finished.
REQ-014 level / world / lives  out  LVL_W / WLD_W / LIV_W  registered counters.
REQ-015 screen  out  3  0 blank, 1 play, 2 lose, 3 win, 4 level-up, 5 world-up, 6 paused.
REQ-016 playerDisable, resetSelect, audioEnable  out  1 each; audioSelect  out  3.

Function
REQ-017 States: INIT, PLAY, PAUSE, LVL_UP, LVL_DISP, WLD_UP, WLD_DISP, LIFE_DECR, LIFE_WAIT, WIN, WIN_WAIT, LOSE, LOSE_WAIT, RESET; unused encodings go to RESET next cycle.
REQ-018 Outputs are Moore decode of current state; defaults screen 0, playerDisable 1, resetSelect 0, audioSelect 7, audioEnable 0.
REQ-019 INIT: screen 1; level 0, world 0, lives START_LIVES; continue_btn=1 -> PLAY.
REQ-020 PLAY: playerDisable 0, screen 1; priority player_dead > level_complete > start_btn edge.
REQ-021 PLAY, player_dead=1: lives>1 -> LIFE_DECR; lives<=1 -> LOSE (lives forced to 0).
REQ-022 PLAY, level_complete=1: level<LEVEL_MAX-1 -> LVL_UP; else world<WORLD_MAX-1 -> WLD_UP; else -> WIN.
REQ-023 PLAY, start_btn rising edge -> PAUSE; PAUSE: screen 6, next start_btn rising edge -> PLAY; other inputs ignored.
REQ-024 LVL_UP (1 cycle): level+1, audioSelect 2, audioEnable 1 -> LVL_DISP.
REQ-025 WLD_UP (1 cycle): world+1, level 0, audioSelect 3, audioEnable 1 -> WLD_DISP.
REQ-026 LVL_DISP screen 4 / WLD_DISP screen 5: exit to PLAY when (continue_btn & seqEnd) or timer reaches DISP_TIMEOUT-1.
REQ-027 Display timer clears on entry to any *_DISP/*_WAIT state, increments each cycle there, never wraps.
REQ-028 LIFE_DECR (1 cycle): lives-1, playerDisable 0, audioSelect 4, audioEnable 1 -> LIFE_WAIT.
REQ-029 LIFE_WAIT: playerDisable 0, audioSelect 1; player_dead=0 -> PLAY, else stay.
REQ-030 WIN (1 cycle): screen 3, audioSelect 5, audioEnable 1 -> WIN_WAIT; LOSE identical with screen 2, audioSelect 6 -> LOSE_WAIT.
REQ-031 WIN_WAIT / LOSE_WAIT: screen held; (continue_btn & seqEnd) or timeout -> RESET.
REQ-032 RESET (1 cycle): resetSelect 1 -> INIT.
REQ-033 Counters never underflow (lives floor 0) nor exceed LIVES_MAX/LEVEL_MAX-1/WORLD_MAX-1.
REQ-034 audioEnable is a single-cycle pulse per event entry.

Reset
REQ-035 rst=1 at a clock edge: state INIT, level 0, world 0, lives START_LIVES, timer 0, start_btn edge register 0; overrides all inputs, mid-operation included.
REQ-036 Outputs during/after reset equal INIT decode: screen 1, playerDisable 1, resetSelect 0, audioSelect 7, audioEnable 0.

Configuration
REQ-037 Macro GAME_BONUS_LIFE_EN defined: WLD_UP also adds 1 life, saturating at LIVES_MAX.
REQ-038 Macro GAME_BONUS_LIFE_EN undefined: WLD_UP leaves lives unchanged; no bonus logic synthesised.

Verification
REQ-039 rst 1 cycle, continue_btn=1 -> PLAY next cycle, lives=7, level=0, world=0, screen=1, playerDisable=0.
REQ-040 In PLAY pulse level_complete twice (with continue_btn&seqEnd between) -> level 2, audioEnable pulsed twice with audioSelect 2; third pulse -> world 1, level 0, screen 5.
REQ-041 player_dead=1 and level_complete=1 same cycle, lives=7 -> LIFE_DECR, lives 6, audioSelect 4; hold player_dead 10 cycles -> stays LIFE_WAIT; release -> PLAY.
REQ-042 lives=1, player_dead=1 -> LOSE, lives 0, screen 2, audioSelect 6; no button for DISP_TIMEOUT (bench value 16) cycles -> RESET, resetSelect 1, then INIT.
REQ-043 start_btn held high 20 cycles in PLAY -> PAUSE only once, screen 6; level_complete ignored; second rising edge -> PLAY.
REQ-044 With GAME_BONUS_LIFE_EN, lives=15, world-up -> lives stays 15; lives=7 -> 8; without macro lives stays 7.
